// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin front end that shares one simple_alu among
// NUM_REQ requesters. One operation is in flight at a time:
//   IDLE (grant) -> ISSUE (alu_start) -> WAIT (RESULT_LAT edges) -> RESP.
// Optional build macro ALU_SCHED_DIVZERO_GUARD_EN: DIV/MOD by zero bypasses
// the ALU and answers all-ones with rsp_err=1.
// Opcode encoding: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5 AND, 6 ACC, 7 MAC.
module alu_rr_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 32,
  parameter int RESULT_LAT = 2
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]  req_a,
  input  logic [NUM_REQ*DATA_W-1:0]  req_b,
  input  logic [NUM_REQ*3-1:0]       req_op,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_data,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic                       alu_start,
  output logic [DATA_W-1:0]          alu_a,
  output logic [DATA_W-1:0]          alu_b,
  output logic [2:0]                 alu_mode,
  input  logic [DATA_W-1:0]          alu_c,
`ifdef ALU_SCHED_DIVZERO_GUARD_EN
  output logic                       rsp_err,
`endif
  output logic                       busy
);

  localparam int IDW   = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(RESULT_LAT);
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOD = 3'd4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                         state_q, state_d;
  logic [IDW-1:0]                 ptr_q, ptr_d, id_q, id_d;
  logic [DATA_W-1:0]              a_q, a_d, b_q, b_d;
  logic [2:0]                     op_q, op_d;
  logic [DATA_W-1:0]              alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]                     alu_mode_q, alu_mode_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [DATA_W-1:0]              rsp_data_q, rsp_data_d;
`ifdef ALU_SCHED_DIVZERO_GUARD_EN
  logic                           err_q, err_d;
  logic                           div0;
`endif

  logic [NUM_REQ-1:0][DATA_W-1:0] a_arr, b_arr;
  logic [NUM_REQ-1:0][2:0]        op_arr;
  logic                           gnt_any;
  logic [IDW-1:0]                 gnt_idx, scan_idx;

  assign a_arr  = req_a;
  assign b_arr  = req_b;
  assign op_arr = req_op;

  // Rotating priority: first valid requester at or after ptr_q, with wrap.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = IDW'((int'(ptr_q) + k) % NUM_REQ);
      if (!gnt_any && req_valid[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = scan_idx;
      end
    end
  end

`ifdef ALU_SCHED_DIVZERO_GUARD_EN
  assign div0 = ((op_arr[gnt_idx] == OP_DIV) || (op_arr[gnt_idx] == OP_MOD)) &&
                (b_arr[gnt_idx] == '0);
`endif

  // Next-state and handshake logic; every register holds unless its state acts on it.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_mode_d = alu_mode_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
`ifdef ALU_SCHED_DIVZERO_GUARD_EN
    err_d      = err_q;
`endif
    req_ready  = '0;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          req_ready[gnt_idx] = 1'b1;
          a_d     = a_arr[gnt_idx];
          b_d     = b_arr[gnt_idx];
          op_d    = op_arr[gnt_idx];
          id_d    = gnt_idx;
          ptr_d   = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
          state_d = ISSUE;
`ifdef ALU_SCHED_DIVZERO_GUARD_EN
          // Division by zero never reaches the ALU.
          if (div0) begin
            rsp_data_d = '1;
            err_d      = 1'b1;
            state_d    = RESP;
          end
`endif
        end
      end
      ISSUE: begin
        // Operands stay on the ALU bus until the next ISSUE.
        alu_a_d    = a_q;
        alu_b_d    = b_q;
        alu_mode_d = op_q;
        cnt_d      = CNT_W'(RESULT_LAT - 1);
        state_d    = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rsp_data_d = alu_c;
`ifdef ALU_SCHED_DIVZERO_GUARD_EN
          err_d      = 1'b0;
`endif
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      id_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_mode_q <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
`ifdef ALU_SCHED_DIVZERO_GUARD_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_mode_q <= alu_mode_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
`ifdef ALU_SCHED_DIVZERO_GUARD_EN
      err_q      <= err_d;
`endif
    end
  end

  // During ISSUE the bus shows the fresh operands; afterwards the held copy.
  assign alu_start = (state_q == ISSUE);
  assign alu_a     = alu_start ? a_q  : alu_a_q;
  assign alu_b     = alu_start ? b_q  : alu_b_q;
  assign alu_mode  = alu_start ? op_q : alu_mode_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = id_q;
  assign busy      = (state_q != IDLE);
`ifdef ALU_SCHED_DIVZERO_GUARD_EN
  assign rsp_err   = err_q;
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler: randomized and directed stimulus for alu_rr_scheduler.
// A cycle-level reference model predicts grants, handshakes and response timing
// and pushes expected responses into a scoreboard; a monitor pops on each
// response handshake. A behavioural ALU drives alu_c, valid only in the
// capture window. Honours ALU_SCHED_DIVZERO_GUARD_EN when defined.
module tb_alu_rr_scheduler;
  localparam int NUM_REQ    = 4;
  localparam int DATA_W     = 32;
  localparam int RESULT_LAT = 2;
  localparam int IDW        = $clog2(NUM_REQ);
  localparam int RESP_AT    = RESULT_LAT + 2;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2,
                         OP_DIV = 3'd3, OP_MOD = 3'd4;
`ifdef ALU_SCHED_DIVZERO_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct { logic [2:0] op; logic [DATA_W-1:0] a; logic [DATA_W-1:0] b; } op_t;
  typedef struct { logic [IDW-1:0] id; logic [DATA_W-1:0] data; logic err; } exp_t;

  logic                      clock = 1'b0;
  logic                      reset_n = 1'b0;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a = '0;
  logic [NUM_REQ*DATA_W-1:0] req_b = '0;
  logic [NUM_REQ*3-1:0]      req_op = '0;
  logic                      rsp_valid;
  logic                      rsp_ready = 1'b0;
  logic [DATA_W-1:0]         rsp_data;
  logic [IDW-1:0]            rsp_id;
  logic                      alu_start;
  logic [DATA_W-1:0]         alu_a, alu_b, alu_c;
  logic [2:0]                alu_mode;
  logic                      busy;
  logic                      rsp_err;

  int checks = 0;
  int errors = 0;
  int rr_mode = 1;     // 0: rsp_ready low, 1: high, 2: random
  bit drop_en = 1'b0;  // randomly withdraw pending req_valid

  op_t  rq[NUM_REQ][$];
  exp_t sb[$];
  exp_t rsp_log[$];

  always #5 clock = ~clock;

  alu_rr_scheduler #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .RESULT_LAT(RESULT_LAT)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_c(alu_c),
`ifdef ALU_SCHED_DIVZERO_GUARD_EN
    .rsp_err(rsp_err),
`endif
    .busy(busy)
  );
`ifndef ALU_SCHED_DIVZERO_GUARD_EN
  assign rsp_err = 1'b0;
`endif

  function automatic logic [DATA_W-1:0] alu_fn(input logic [2:0] op,
                                              input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a * b;
      3'd3:    return (b == '0) ? a : a / b;
      3'd4:    return (b == '0) ? a : a % b;
      3'd5:    return a & b;
      3'd6:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // Behavioural ALU: result is correct only in the cycle before the capture edge.
  logic [DATA_W-1:0] alu_res_q = '0;
  int                alu_age   = 100;
  always @(posedge clock) begin
    if (alu_start) begin
      alu_res_q <= alu_fn(alu_mode, alu_a, alu_b);
      alu_age   <= 0;
    end else if (alu_age < 1000) begin
      alu_age   <= alu_age + 1;
    end
  end
  assign alu_c = (alu_age == RESULT_LAT - 1) ? alu_res_q : ~alu_res_q;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: m_cnt = 0 when free, else cycles since the grant cycle.
  int                m_cnt = 0;
  int                m_ptr = 0;
  int                m_g;
  logic [NUM_REQ-1:0] m_er;
  logic [DATA_W-1:0] m_a, m_b;
  logic [2:0]        m_op;

  task automatic model_step();
    exp_t e;
    bit   div0;
    if (!reset_n) begin
      m_cnt = 0;
      m_ptr = 0;
      sb.delete();
      return;
    end
    m_g  = -1;
    m_er = '0;
    if (m_cnt == 0)
      for (int k = 0; k < NUM_REQ; k++)
        if (m_g < 0 && req_valid[(m_ptr + k) % NUM_REQ]) m_g = (m_ptr + k) % NUM_REQ;
    if (m_g >= 0) m_er[m_g] = 1'b1;
    chk("req_ready", req_ready, m_er);
    chk("busy", busy, m_cnt != 0);
    chk("rsp_valid", rsp_valid, m_cnt == RESP_AT);
    chk("alu_start", alu_start, m_cnt == 1);
    if (m_cnt == 1) begin
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_mode", alu_mode, m_op);
    end
    if (m_cnt == 0) begin
      if (m_g >= 0) begin
        m_a    = req_a[m_g*DATA_W +: DATA_W];
        m_b    = req_b[m_g*DATA_W +: DATA_W];
        m_op   = req_op[m_g*3 +: 3];
        div0   = (m_op == OP_DIV || m_op == OP_MOD) && m_b == '0;
        e.id   = IDW'(m_g);
        e.err  = GUARD && div0;
        e.data = e.err ? '1 : alu_fn(m_op, m_a, m_b);
        sb.push_back(e);
        m_ptr  = (m_g + 1) % NUM_REQ;
        m_cnt  = e.err ? RESP_AT : 1;
      end
    end else if (m_cnt < RESP_AT) begin
      m_cnt++;
    end else if (rsp_ready) begin
      m_cnt = 0;
    end
  endtask

  initial forever begin
    @(negedge clock);
    model_step();
  end

  // Monitor: every presented response must match the scoreboard head.
  initial forever begin
    exp_t got;
    @(negedge clock);
    if (reset_n && rsp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: unexpected response id %0d data %0h", rsp_id, rsp_data);
      end else begin
        chk("rsp_data", rsp_data, sb[0].data);
        chk("rsp_id", rsp_id, sb[0].id);
        chk("rsp_err", rsp_err, sb[0].err);
        if (rsp_ready) begin
          got.id = rsp_id; got.data = rsp_data; got.err = rsp_err;
          rsp_log.push_back(got);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rq[i].size() > 0) begin
        req_a[i*DATA_W +: DATA_W] = rq[i][0].a;
        req_b[i*DATA_W +: DATA_W] = rq[i][0].b;
        req_op[i*3 +: 3]          = rq[i][0].op;
        req_valid[i] = !drop_en || ($urandom_range(3) != 0);
      end else begin
        req_valid[i] = 1'b0;
      end
    end
    case (rr_mode)
      0:       rsp_ready = 1'b0;
      1:       rsp_ready = 1'b1;
      default: rsp_ready = 1'($urandom_range(1));
    endcase
  endtask

  task automatic step();
    logic [NUM_REQ-1:0] hs;
    @(negedge clock);
    hs = reset_n ? (req_valid & req_ready) : '0;
    @(posedge clock);
    #1;
    for (int i = 0; i < NUM_REQ; i++)
      if (hs[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    drive();
  endtask

  task automatic push_op(input int i, input logic [2:0] op, input logic [DATA_W-1:0] a,
                         input logic [DATA_W-1:0] b);
    op_t o;
    o.op = op; o.a = a; o.b = b;
    rq[i].push_back(o);
    drive();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_alu_start"}, alu_start, 0);
    chk({tag, "_alu_a"}, alu_a, 0);
    chk({tag, "_alu_b"}, alu_b, 0);
    chk({tag, "_alu_mode"}, alu_mode, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
    drive();
    #1;
    chk_all_zero(tag);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    rsp_log.delete();
  endtask

  function automatic bit pending();
    bit p = (m_cnt != 0);
    for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic drain(input int maxc);
    int n = 0;
    while (pending() && n < maxc) begin step(); n++; end
    if (n >= maxc) begin
      checks++; errors++;
      $display("FAIL drain_timeout: still busy after %0d cycles", maxc);
    end
  endtask

  task automatic wait_model(input int target, input int maxc);
    int n = 0;
    while (m_cnt != target && n < maxc) begin step(); n++; end
    if (n >= maxc) begin
      checks++; errors++;
      $display("FAIL wait_timeout: model state %0d never reached %0d", m_cnt, target);
    end
  endtask

  task automatic rand_phase(input int cycles);
    rr_mode = 2;
    drop_en = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      if ($urandom_range(2) == 0) begin
        int r = $urandom_range(NUM_REQ - 1);
        logic [2:0] op = 3'($urandom_range(5));
        logic [DATA_W-1:0] a = $urandom;
        logic [DATA_W-1:0] b = ($urandom_range(5) == 0) ? '0 :
                               ($urandom_range(1) != 0) ? DATA_W'($urandom_range(1000)) : $urandom;
        if (rq[r].size() < 3) push_op(r, op, a, b);
      end
      step();
    end
    drop_en = 1'b0;
    rr_mode = 1;
    drive();
    drain(400);
  endtask

  initial begin
    int   exp_id[5];
    int   exp_dat[5];
    exp_id  = '{0, 1, 2, 3, 0};
    exp_dat = '{7, 42, 2, 25, 18};

    do_reset("rst");

    // Single ADD from requester 1.
    push_op(1, OP_ADD, 5, 7);
    drain(50);
    chk("add_count", rsp_log.size(), 1);
    if (rsp_log.size() > 0) begin
      chk("add_data", rsp_log[0].data, 12);
      chk("add_id", rsp_log[0].id, 1);
    end

    // All requesters valid from reset: rotation 0,1,2,3,0.
    do_reset("rst_b");
    push_op(0, OP_SUB, 10, 3);
    push_op(1, OP_MUL, 6, 7);
    push_op(2, OP_ADD, 1, 1);
    push_op(3, OP_DIV, 100, 4);
    push_op(0, OP_ADD, 9, 9);
    drain(100);
    chk("rr_count", rsp_log.size(), 5);
    for (int i = 0; i < 5 && i < rsp_log.size(); i++) begin
      chk("rr_id", rsp_log[i].id, exp_id[i]);
      chk("rr_data", rsp_log[i].data, exp_dat[i]);
    end

    // Response back-pressure for 10 cycles with other requests waiting.
    rr_mode = 0;
    push_op(3, OP_SUB, 50, 8);
    wait_model(RESP_AT, 20);
    push_op(0, OP_ADD, 2, 2);
    push_op(2, OP_MOD, 17, 5);
    repeat (10) step();
    chk("stall_busy", busy, 1);
    chk("stall_valid", rsp_valid, 1);
    rr_mode = 1;
    drive();
    drain(100);

    // Reset during WAIT drops the operation; next grant restarts at requester 0.
    push_op(1, OP_ADD, 3, 4);
    wait_model(2, 20);
    do_reset("rst_wait");
    push_op(2, OP_ADD, 20, 1);
    push_op(1, OP_ADD, 10, 1);
    push_op(0, OP_ADD, 30, 1);
    push_op(3, OP_ADD, 40, 1);
    drain(100);
    chk("rst_count", rsp_log.size(), 4);
    if (rsp_log.size() > 0) begin
      chk("rst_first_id", rsp_log[0].id, 0);
      chk("rst_first_data", rsp_log[0].data, 31);
    end

    // Truncated multiply.
    rsp_log.delete();
    push_op(0, OP_MUL, 32'hFFFF_FFFF, 2);
    drain(50);
    if (rsp_log.size() > 0) chk("mul_trunc", rsp_log[0].data, 32'hFFFF_FFFE);
    else chk("mul_count", rsp_log.size(), 1);

    // Divide by zero from requester 2.
    rsp_log.delete();
    push_op(2, OP_DIV, 77, 0);
    drain(50);
    if (rsp_log.size() > 0) begin
      chk("div0_data", rsp_log[0].data, GUARD ? 32'hFFFF_FFFF : 32'd77);
      chk("div0_err", rsp_log[0].err, GUARD);
      chk("div0_id", rsp_log[0].id, 2);
    end else chk("div0_count", rsp_log.size(), 1);

    rand_phase(800);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
